// File: rtl/mul_pkg.sv
// ============================================================================
// Module : mul_pkg
// Brief  : Shared operand-mode constants and types for the pipelined multiplier.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    typedef logic mul_mode_t;

    localparam mul_mode_t MUL_MODE_UNSIGNED = 1'b0;
    localparam mul_mode_t MUL_MODE_SIGNED   = 1'b1;

endpackage : mul_pkg

`default_nettype wire

// File: rtl/mul_pipe_stage.sv
// ============================================================================
// Module : mul_pipe_stage
// Brief  : One elastic valid/ready register slice with a generic payload.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_pipe_stage #(
    parameter int PAYLOAD_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] data_q,  data_d;

    // Loads when empty or when the held entry leaves this same cycle.
    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule : mul_pipe_stage

`default_nettype wire

// File: rtl/mul_pipe.sv
// ============================================================================
// Module : mul_pipe
// Brief  : Pipelined valid/ready signed/unsigned multiplier; optional
//          round/shift/saturate output when MUL_PIPE_RND_SAT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH_MUL_INPUT1 = 8,
    parameter int WIDTH_MUL_INPUT2 = 8,
    parameter int WIDTH_MUL        = WIDTH_MUL_INPUT1 + WIDTH_MUL_INPUT2,
    parameter int NUM_STAGES       = 2,
    parameter int SHIFT            = 0,
    parameter int WIDTH_OUT        = WIDTH_MUL
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_signed,
    input  logic [WIDTH_MUL_INPUT1-1:0] mul_input1,
    input  logic [WIDTH_MUL_INPUT2-1:0] mul_input2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH_MUL-1:0]        mul,
    output logic                        mul_sat
);

    typedef struct packed {
        mul_mode_t            mode;
        logic [WIDTH_MUL-1:0] prod;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    if (WIDTH_MUL_INPUT1 < 2 || WIDTH_MUL_INPUT2 < 2 || NUM_STAGES < 1 ||
        WIDTH_MUL != WIDTH_MUL_INPUT1 + WIDTH_MUL_INPUT2 ||
        SHIFT < 0 || SHIFT >= WIDTH_MUL || WIDTH_OUT < 2 || WIDTH_OUT > WIDTH_MUL) begin : g_bad_cfg
        $error("mul_pipe: illegal parameter combination");
    end

    logic [WIDTH_MUL-1:0] op1_ext, op2_ext;
    payload_t             in_pl;
    payload_t             last_pl;

    logic                 stg_valid [0:NUM_STAGES];
    logic                 stg_ready [0:NUM_STAGES];
    logic [PAYLOAD_W-1:0] stg_data  [0:NUM_STAGES];

    always_comb begin
        if (in_signed == MUL_MODE_SIGNED) begin
            op1_ext = {{WIDTH_MUL_INPUT2{mul_input1[WIDTH_MUL_INPUT1-1]}}, mul_input1};
            op2_ext = {{WIDTH_MUL_INPUT1{mul_input2[WIDTH_MUL_INPUT2-1]}}, mul_input2};
        end else begin
            op1_ext = {{WIDTH_MUL_INPUT2{1'b0}}, mul_input1};
            op2_ext = {{WIDTH_MUL_INPUT1{1'b0}}, mul_input2};
        end
        in_pl.mode = in_signed;
        in_pl.prod = op1_ext * op2_ext;
    end

    assign stg_valid[0]          = in_valid;
    assign stg_data[0]           = in_pl;
    assign in_ready              = stg_ready[0];
    assign stg_ready[NUM_STAGES] = out_ready;
    assign out_valid             = stg_valid[NUM_STAGES];
    assign last_pl               = payload_t'(stg_data[NUM_STAGES]);

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        mul_pipe_stage #(
            .PAYLOAD_W (PAYLOAD_W)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (stg_valid[k]),
            .in_ready_o  (stg_ready[k]),
            .in_data_i   (stg_data[k]),
            .out_valid_o (stg_valid[k+1]),
            .out_ready_i (stg_ready[k+1]),
            .out_data_o  (stg_data[k+1])
        );
    end

`ifdef MUL_PIPE_RND_SAT_EN
    localparam logic [WIDTH_MUL:0] ONE  = (WIDTH_MUL+1)'(1);
    localparam logic [WIDTH_MUL:0] BIAS = (ONE << SHIFT) >> 1;
    localparam logic [WIDTH_MUL:0] SMAX = (ONE << (WIDTH_OUT-1)) - ONE;
    localparam logic [WIDTH_MUL:0] SMIN = ~SMAX;
    localparam logic [WIDTH_MUL:0] UMAX = (ONE << WIDTH_OUT) - ONE;

    logic [WIDTH_MUL:0] rs_ext, rs_sum, rs_shift, rs_clamp;
    logic               rs_sat;

    // One guard bit keeps the rounding add exact for both signednesses.
    always_comb begin
        rs_ext = (last_pl.mode == MUL_MODE_SIGNED) ?
                 {last_pl.prod[WIDTH_MUL-1], last_pl.prod} : {1'b0, last_pl.prod};
        rs_sum = rs_ext + BIAS;
        if (last_pl.mode == MUL_MODE_SIGNED) begin
            rs_shift = $unsigned($signed(rs_sum) >>> SHIFT);
        end else begin
            rs_shift = rs_sum >> SHIFT;
        end
        rs_clamp = rs_shift;
        rs_sat   = 1'b0;
        if (last_pl.mode == MUL_MODE_SIGNED) begin
            if ($signed(rs_shift) > $signed(SMAX)) begin
                rs_clamp = SMAX;
                rs_sat   = 1'b1;
            end else if ($signed(rs_shift) < $signed(SMIN)) begin
                rs_clamp = SMIN;
                rs_sat   = 1'b1;
            end
        end else if (rs_shift > UMAX) begin
            rs_clamp = UMAX;
            rs_sat   = 1'b1;
        end
    end

    assign mul     = rs_clamp[WIDTH_MUL-1:0];
    assign mul_sat = rs_sat;
`else
    assign mul     = last_pl.prod;
    assign mul_sat = 1'b0;
`endif

endmodule : mul_pipe

`default_nettype wire

// File: tb/tb_mul_pipe.sv
// ============================================================================
// Module : tb_mul_pipe
// Brief  : Self-checking bench for mul_pipe (directed + random vs. model).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_pipe;

    localparam int W1 = 8;
    localparam int W2 = 8;
    localparam int WM = W1 + W2;
    localparam int NS = 2;
`ifdef MUL_PIPE_RND_SAT_EN
    localparam int SH = 7;
    localparam int WO = 8;
`else
    localparam int SH = 0;
    localparam int WO = WM;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_signed;
    logic [W1-1:0] mul_input1;
    logic [W2-1:0] mul_input2;
    logic          out_valid, out_ready;
    logic [WM-1:0] mul;
    logic          mul_sat;

    int tests_run = 0;
    int failed    = 0;
    int n_acc     = 0;
    int n_out     = 0;
    int n_stall   = 0;
    logic [WM:0] exp_q [$];

    mul_pipe #(
        .WIDTH_MUL_INPUT1 (W1),
        .WIDTH_MUL_INPUT2 (W2),
        .NUM_STAGES       (NS),
        .SHIFT            (SH),
        .WIDTH_OUT        (WO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .mul_input1 (mul_input1),
        .mul_input2 (mul_input2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mul        (mul),
        .mul_sat    (mul_sat)
    );

    always #5 clk = ~clk;

    // Reference result {sat, value} computed with plain integer arithmetic.
    function automatic logic [WM:0] model(input logic [W1-1:0] a, input logic [W2-1:0] b,
                                          input logic s);
        int sa, sb, p, q, lo, hi;
        logic sat;
        logic [31:0] qv;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        p  = sa * sb;
        q  = p;
        sat = 1'b0;
`ifdef MUL_PIPE_RND_SAT_EN
        q = p + ((SH > 0) ? (1 << (SH - 1)) : 0);
        q = s ? (q >>> SH) : int'($unsigned(q) >> SH);
        lo = s ? -(1 << (WO - 1)) : 0;
        hi = s ? (1 << (WO - 1)) - 1 : (1 << WO) - 1;
        if (q > hi) begin q = hi; sat = 1'b1; end
        if (q < lo) begin q = lo; sat = 1'b1; end
`else
        lo = 0;
        hi = 0;
`endif
        qv = q;
        return {sat, qv[WM-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic; the scoreboard is updated from observed handshakes.
    task automatic cycle(input logic v, input logic [W1-1:0] a, input logic [W2-1:0] b,
                         input logic s, input logic ordy);
        logic [WM:0] e;
        @(negedge clk);
        in_valid = v; mul_input1 = a; mul_input2 = b; in_signed = s; out_ready = ordy;
        #1;
        if (v && !in_ready) n_stall++;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, s));
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_output", 64'(out_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("stream_result", 64'({mul_sat, mul}), 64'(e));
            end
        end
        @(posedge clk);
    endtask

    // Single transaction: checks exact NUM_STAGES-cycle latency and result.
    task automatic single(input string tag, input logic [W1-1:0] a, input logic [W2-1:0] b,
                          input logic s, input logic [WM:0] exp);
        @(negedge clk);
        in_valid = 1'b1; mul_input1 = a; mul_input2 = b; in_signed = s; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'({mul_sat, mul}), 64'(exp));
        @(posedge clk);
    endtask

    initial begin
        int        acc0, out0;
        logic [WM:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        mul_input1 = '0; mul_input2 = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mul", 64'(mul), 64'd0);
        check("rst_mul_sat", 64'(mul_sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

`ifdef MUL_PIPE_RND_SAT_EN
        single("s_m128sq", 8'h80, 8'h80, 1'b1, {1'b1, 16'd127});
        single("s_3x64",   8'd3,  8'd64, 1'b1, {1'b0, 16'd2});
        single("u_255sq",  8'hFF, 8'hFF, 1'b0, model(8'hFF, 8'hFF, 1'b0));
        single("s_ff_sq",  8'hFF, 8'hFF, 1'b1, model(8'hFF, 8'hFF, 1'b1));
`else
        single("s_m128sq", 8'h80, 8'h80, 1'b1, {1'b0, 16'h4000});
        single("u_255sq",  8'hFF, 8'hFF, 1'b0, {1'b0, 16'hFE01});
        single("s_ff_sq",  8'hFF, 8'hFF, 1'b1, {1'b0, 16'h0001});
        single("s_m128x127", 8'h80, 8'h7F, 1'b1, model(8'h80, 8'h7F, 1'b1));
`endif

        // Streaming: 100 random pairs at full rate.
        n_stall = 0; out0 = n_out;
        for (int i = 0; i < 100; i++)
            cycle(1'b1, W1'($urandom), W2'($urandom), 1'($urandom), 1'b1);
        check("stream_outs_during_fill", 64'(n_out - out0), 64'(100 - NS));
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("stream_no_bubbles", 64'(n_stall), 64'd0);
        check("stream_all_out", 64'(n_out - out0), 64'd100);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: downstream stalled for 5 cycles.
        acc0 = n_acc;
        for (int i = 0; i < 5; i++)
            cycle(1'b1, W1'($urandom), W2'($urandom), 1'($urandom), 1'b0);
        check("bp_accepts", 64'(n_acc - acc0), 64'(NS));
        held = exp_q[0];
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_held_result", 64'({mul_sat, mul}), 64'(held));
        @(posedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_all_out", 64'(n_out - out0), 64'(100 + NS));

        // Reset with two entries in flight.
        cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        cycle(1'b1, 8'h56, 8'h78, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_mul", 64'(mul), 64'd0);
        exp_q.delete();
        out0 = n_out;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("midrst_nothing_emerges", 64'(n_out - out0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule : tb_mul_pipe

`default_nettype wire
